// File: rtl/distance_filter_if.sv
// rtl/distance_filter_if.sv - distance input and filtered-output bundle for distance_filter.
interface distance_filter_if;
  logic [19:0] distance_in;
  logic        sample_tick;
  logic [19:0] filt_dist;
  logic        filt_valid;
  logic        obstacle;

  modport slave (
    input  distance_in,
    output sample_tick, filt_dist, filt_valid, obstacle
  );

  modport master (
    output distance_in,
    input  sample_tick, filt_dist, filt_valid, obstacle
  );
endinterface

// File: rtl/distance_filter.sv
// rtl/distance_filter.sv - periodic distance sampler with moving average and debounced obstacle flag.
// Optional DIST_CLIP_EN: accept readings above MAX_CM and clip them instead of rejecting.
module distance_filter #(
  parameter int SAMPLE_CYCLES = 10_000_000,
  parameter int DEPTH_LOG2    = 2,
  parameter int NEAR_CM       = 20,
  parameter int FAR_CM        = 25,
  parameter int DEBOUNCE      = 3,
  parameter int MAX_CM        = 400
) (
  input  logic             clk,
  input  logic             rst,
  distance_filter_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(SAMPLE_CYCLES);
  localparam int SW    = 20 + DEPTH_LOG2;
  localparam int DW    = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {CLEAR, ARMING, NEAR, RELEASING} state_t;

  logic [CW-1:0]         cnt;
  logic                  tick;
  logic                  accept;
  logic [19:0]           sample;
  logic [19:0]           buf_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2:0]   fill;
  logic [SW-1:0]         sum;
  logic                  s1_valid;
  logic                  s2_valid;
  logic [19:0]           filt_dist;
  logic                  filt_valid;
  logic                  eval;
  logic                  near;
  logic                  far;
  state_t                state;
  state_t                state_next;
  logic [DW-1:0]         dbc;
  logic [DW-1:0]         dbc_next;

  assign tick = (cnt == CW'(SAMPLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

  always_comb begin
    sample = bus.distance_in;
    accept = (bus.distance_in != 20'd0);
`ifdef DIST_CLIP_EN
    if (bus.distance_in > 20'(MAX_CM)) sample = 20'(MAX_CM);
`else
    if (bus.distance_in > 20'(MAX_CM)) accept = 1'b0;
`endif
  end

  // The entry being overwritten is subtracted so the sum always covers exactly the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
      wptr     <= '0;
      fill     <= '0;
      sum      <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= tick && accept;
      if (tick && accept) begin
        sum           <= sum + SW'(sample) - SW'(buf_mem[wptr]);
        buf_mem[wptr] <= sample;
        wptr          <= wptr + 1'b1;
        if (fill != (DEPTH_LOG2 + 1)'(DEPTH)) fill <= fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_dist  <= '0;
      filt_valid <= 1'b0;
      s2_valid   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        filt_dist <= 20'(sum >> DEPTH_LOG2);
        if (fill == (DEPTH_LOG2 + 1)'(DEPTH)) filt_valid <= 1'b1;
      end
    end
  end

  assign eval = s2_valid && filt_valid;
  assign near = (filt_dist < 20'(NEAR_CM));
  assign far  = (filt_dist > 20'(FAR_CM));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      dbc   <= '0;
    end else begin
      state <= state_next;
      dbc   <= dbc_next;
    end
  end

  // Readings inside the NEAR_CM..FAR_CM band qualify in no state, giving hysteresis.
  always_comb begin
    state_next = state;
    dbc_next   = dbc;
    if (eval) begin
      case (state)
        CLEAR: begin
          if (near) begin
            dbc_next   = (DEBOUNCE == 1) ? '0 : DW'(1);
            state_next = (DEBOUNCE == 1) ? NEAR : ARMING;
          end else begin
            dbc_next = '0;
          end
        end
        ARMING: begin
          if (near && (dbc + 1'b1 == DW'(DEBOUNCE))) begin
            state_next = NEAR;
            dbc_next   = '0;
          end else if (near) begin
            dbc_next = dbc + 1'b1;
          end else begin
            state_next = CLEAR;
            dbc_next   = '0;
          end
        end
        NEAR: begin
          if (far) begin
            dbc_next   = (DEBOUNCE == 1) ? '0 : DW'(1);
            state_next = (DEBOUNCE == 1) ? CLEAR : RELEASING;
          end else begin
            dbc_next = '0;
          end
        end
        RELEASING: begin
          if (far && (dbc + 1'b1 == DW'(DEBOUNCE))) begin
            state_next = CLEAR;
            dbc_next   = '0;
          end else if (far) begin
            dbc_next = dbc + 1'b1;
          end else begin
            state_next = NEAR;
            dbc_next   = '0;
          end
        end
        default: begin
          state_next = CLEAR;
          dbc_next   = '0;
        end
      endcase
    end
  end

  assign bus.sample_tick = tick;
  assign bus.filt_dist   = filt_dist;
  assign bus.filt_valid  = filt_valid;
  assign bus.obstacle    = (state == NEAR) || (state == RELEASING);
endmodule

// File: tb/tb_distance_filter.sv
// tb/tb_distance_filter.sv - directed and randomized checks of distance_filter against a window/debounce model.
module tb_distance_filter;
  localparam int SC   = 16;
  localparam int WIN  = 4;
  localparam int NEAR = 20;
  localparam int FAR  = 25;
  localparam int DEB  = 3;
  localparam int MAXC = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  distance_filter_if dif();

  distance_filter #(.SAMPLE_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  int tests = 0;
  int fails = 0;

  int win[$];
  int accepted;
  bit m_obst;
  int m_run;
  int m_filt;
  bit m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    accepted = 0;
    m_obst   = 0;
    m_run    = 0;
    m_filt   = 0;
    m_valid  = 0;
  endtask

  task automatic model_sample(input int d);
    int v;
    int s;
    bit ok;
    bit qual;
    v  = d;
    ok = (d != 0);
    if (d > MAXC) begin
`ifdef DIST_CLIP_EN
      v = MAXC;
`else
      ok = 0;
`endif
    end
    if (ok) begin
      win.push_back(v);
      if (win.size() > WIN) win.delete(0);
      accepted++;
      s = 0;
      foreach (win[i]) s += win[i];
      m_filt = s / WIN;
      if (accepted >= WIN) m_valid = 1;
      if (m_valid) begin
        qual = m_obst ? (m_filt > FAR) : (m_filt < NEAR);
        m_run = qual ? m_run + 1 : 0;
        if (m_run == DEB) begin
          m_obst = !m_obst;
          m_run  = 0;
        end
      end
    end
  endtask

  // Entered and left at a negedge; checks filtered outputs at T+2 and the flag at T+2/T+3.
  task automatic do_sample(input int d, input string tag);
    int n;
    bit prev_obst;
    n = 0;
    dif.distance_in = 20'(d);
    while (dif.sample_tick !== 1'b1 && n < 3 * SC) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tick"}, 32'(dif.sample_tick), 32'd1);
    prev_obst = m_obst;
    model_sample(d);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_filt_dist"}, 32'(dif.filt_dist), 32'(m_filt));
    chk({tag, "_filt_valid"}, 32'(dif.filt_valid), 32'(m_valid));
    chk({tag, "_obst_hold"}, 32'(dif.obstacle), 32'(prev_obst));
    @(negedge clk);
    chk({tag, "_obstacle"}, 32'(dif.obstacle), 32'(m_obst));
  endtask

  task automatic do_reset(input string tag);
    int n;
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_rst_tick"}, 32'(dif.sample_tick), 32'd0);
    chk({tag, "_rst_filt"}, 32'(dif.filt_dist), 32'd0);
    chk({tag, "_rst_valid"}, 32'(dif.filt_valid), 32'd0);
    chk({tag, "_rst_obst"}, 32'(dif.obstacle), 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dif.sample_tick !== 1'b1 && n < 3 * SC);
    // Counter restarts at 0 in the first free cycle, so the tick is SC-1 edges later.
    chk({tag, "_first_tick"}, 32'(n), 32'(SC - 1));
  endtask

  initial begin
    int d;
    int cat;
    dif.distance_in = 20'd0;
    model_reset();
    do_reset("init");

    for (int i = 0; i < 4; i++) do_sample(100, "fill100");
    chk("fill100_avg", 32'(dif.filt_dist), 32'd100);

    for (int i = 0; i < 6; i++) do_sample(10, "drop10");
    chk("drop10_near", 32'(dif.obstacle), 32'd1);

    for (int i = 0; i < 4; i++) begin
      do_sample(26, "band_a");
      do_sample(20, "band_b");
    end
    chk("band_hold", 32'(dif.obstacle), 32'd1);
    for (int i = 0; i < 4; i++) do_sample(30, "far30");
    chk("far30_clear", 32'(dif.obstacle), 32'd0);

    for (int i = 0; i < 4; i++) do_sample(100, "refill");
    do_sample(0, "zero");
    chk("zero_hold", 32'(dif.filt_dist), 32'd100);
    do_sample(500, "over");
`ifdef DIST_CLIP_EN
    chk("over_clip", 32'(dif.filt_dist), 32'd175);
`else
    chk("over_reject", 32'(dif.filt_dist), 32'd100);
`endif

    dif.distance_in = 20'd50;
    while (dif.sample_tick !== 1'b1) @(negedge clk);
    @(negedge clk);
    do_reset("mid");
    do_sample(40, "post_rst");

    for (int i = 0; i < 70; i++) begin
      cat = $urandom_range(0, 19);
      if (cat < 6)       d = $urandom_range(1, 15);
      else if (cat < 10) d = $urandom_range(20, 25);
      else if (cat < 15) d = $urandom_range(26, 60);
      else if (cat < 17) d = 0;
      else if (cat < 19) d = $urandom_range(401, 1000);
      else               d = $urandom_range(100, 400);
      do_sample(d, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
